// File: rtl/rps_pkg.sv
// Shared rock-paper-scissors types: moves, round results, controller states and the beats() rule.
package rps_pkg;

    typedef enum logic [1:0] {ROCK = 2'd0, PAPER = 2'd1, SCISSORS = 2'd2} move_t;
    typedef enum logic [1:0] {RES_NONE = 2'd0, RES_DRAW = 2'd1, RES_PLAYER = 2'd2, RES_AI = 2'd3} result_t;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_PRED, S_JUDGE, S_UPDATE, S_OVER} state_t;

    localparam logic [1:0] MOVE_ILLEGAL = 2'b11;

    // The move that defeats 'move'.
    function automatic logic [1:0] beats(input logic [1:0] move);
        return (move == 2'd2) ? 2'd0 : move + 2'd1;
    endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round referee: who won given the player's and the controller's moves.
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] player,
    input  logic [1:0] ai,
    output logic [1:0] result
);

    always_comb begin
        if (player == ai)
            result = RES_DRAW;
        else if (ai == beats(player))
            result = RES_AI;
        else
            result = RES_PLAYER;
    end

endmodule

// File: rtl/rps_round_ctrl.sv
// Round sequencer: latch move, query predictor, counter it, judge, score, send learning update.
// Optional match limit (OVER state) is built only with RPS_MATCH_LIMIT_EN defined.
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int PRED_TIMEOUT = 8,
    parameter int MATCH_WINS   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               play_valid,
    input  logic [1:0]         play_move,
    output logic               pred_req,
    output logic [3:0]         pred_hist,
    input  logic               pred_valid,
    input  logic [1:0]         pred_move,
    output logic               upd_valid,
    output logic [3:0]         upd_hist,
    output logic [1:0]         upd_move,
    output logic               result_valid,
    output logic [1:0]         ai_move,
    output logic [1:0]         result,
    output logic [SCORE_W-1:0] score_player,
    output logic [SCORE_W-1:0] score_ai,
    output logic               busy,
    output logic               match_over
);

    localparam int                 TMR_W     = $clog2(PRED_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(PRED_TIMEOUT);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             state;
    logic [1:0]         fb_ctr;
    logic [1:0]         player;
    logic [3:0]         hist;
    logic [TMR_W-1:0]   timer;
    logic               go_judge;
    logic [1:0]         pred_sel;
    logic [1:0]         ai_next;
    logic [1:0]         res_next;
    logic [SCORE_W-1:0] sp_next;
    logic [SCORE_W-1:0] sa_next;

    // Only meaningful in REQ / WAIT_PRED; a real answer beats a same-cycle timeout.
    assign go_judge = pred_valid || (state == S_WAIT_PRED && timer == TMR_LAST);
    // An illegal prediction is as good as no answer: fall back to the rotating counter.
    assign pred_sel = (pred_valid && pred_move != MOVE_ILLEGAL) ? pred_move : fb_ctr;
    assign ai_next  = beats(pred_sel);

    rps_judge u_judge (
        .player (player),
        .ai     (ai_next),
        .result (res_next)
    );

    assign sp_next = (res_next == RES_PLAYER && score_player != SCORE_MAX) ? score_player + 1'b1 : score_player;
    assign sa_next = (res_next == RES_AI && score_ai != SCORE_MAX) ? score_ai + 1'b1 : score_ai;

`ifdef RPS_MATCH_LIMIT_EN
    localparam logic [SCORE_W-1:0] WIN_CNT = SCORE_W'(MATCH_WINS);
    logic match_end;
`else
    assign match_over = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            fb_ctr       <= '0;
            player       <= '0;
            hist         <= '0;
            timer        <= '0;
            pred_req     <= 1'b0;
            pred_hist    <= '0;
            upd_valid    <= 1'b0;
            upd_hist     <= '0;
            upd_move     <= '0;
            result_valid <= 1'b0;
            ai_move      <= '0;
            result       <= '0;
            score_player <= '0;
            score_ai     <= '0;
            busy         <= 1'b0;
`ifdef RPS_MATCH_LIMIT_EN
            match_over   <= 1'b0;
            match_end    <= 1'b0;
`endif
        end else begin
            fb_ctr       <= (fb_ctr == 2'd2) ? 2'd0 : fb_ctr + 2'd1;
            pred_req     <= 1'b0;
            upd_valid    <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (play_valid && play_move != MOVE_ILLEGAL) begin
                        player    <= play_move;
                        pred_req  <= 1'b1;
                        pred_hist <= hist;
                        busy      <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ, S_WAIT_PRED: begin
                    timer <= (state == S_REQ) ? TMR_W'(1) : timer + 1'b1;
                    if (go_judge) begin
                        ai_move      <= ai_next;
                        result       <= res_next;
                        result_valid <= 1'b1;
                        score_player <= sp_next;
                        score_ai     <= sa_next;
`ifdef RPS_MATCH_LIMIT_EN
                        match_end    <= (sp_next == WIN_CNT) || (sa_next == WIN_CNT);
`endif
                        state        <= S_JUDGE;
                    end else begin
                        state <= S_WAIT_PRED;
                    end
                end
                S_JUDGE: begin
                    upd_valid <= 1'b1;
                    upd_hist  <= hist;
                    upd_move  <= player;
                    state     <= S_UPDATE;
                end
                S_UPDATE: begin
                    hist <= {player, ai_move};
                    busy <= 1'b0;
`ifdef RPS_MATCH_LIMIT_EN
                    if (match_end) begin
                        match_over <= 1'b1;
                        state      <= S_OVER;
                    end else begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= state;  // OVER: parked until reset
            endcase
        end
    end

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Directed bench for rps_round_ctrl; expectations are laid out per cycle from the round rules.
module tb_rps_round_ctrl;

    localparam int SCORE_W = 4;
    localparam int PT      = 8;
    localparam int MW      = 2;
    localparam int N       = 2048;
    localparam int SMAX    = (1 << SCORE_W) - 1;
    localparam logic [1:0] RK = 2'd0, PA = 2'd1, SC = 2'd2, BAD = 2'd3;

    logic clock = 1'b0, reset = 1'b0;
    logic play_valid = 1'b0, pred_valid = 1'b0;
    logic [1:0] play_move = 2'd0, pred_move = 2'd0;
    logic pred_req, upd_valid, result_valid, busy, match_over;
    logic [3:0] pred_hist, upd_hist;
    logic [1:0] upd_move, ai_move, result;
    logic [SCORE_W-1:0] score_player, score_ai;

    rps_round_ctrl #(.SCORE_W(SCORE_W), .PRED_TIMEOUT(PT), .MATCH_WINS(MW)) dut (
        .clock(clock), .reset(reset),
        .play_valid(play_valid), .play_move(play_move),
        .pred_req(pred_req), .pred_hist(pred_hist),
        .pred_valid(pred_valid), .pred_move(pred_move),
        .upd_valid(upd_valid), .upd_hist(upd_hist), .upd_move(upd_move),
        .result_valid(result_valid), .ai_move(ai_move), .result(result),
        .score_player(score_player), .score_ai(score_ai),
        .busy(busy), .match_over(match_over)
    );

    always #5 clock = ~clock;

    // Per-cycle expectations, indexed by absolute cycle t.
    int e_preq[N], e_phist[N], e_rv[N], e_uv[N], e_uhist[N], e_umove[N];
    int e_ai[N], e_res[N], e_sp[N], e_sa[N], e_busy[N], e_mo[N];

    int  t = 0, cyc = 0;
    int  m_hist = 0, m_sp = 0, m_sa = 0;
    bit  m_over = 1'b0, chk_en = 1'b0;
    int  n_tests = 0, n_fail = 0;
    int  n_preq = 0, n_uv = 0, last_phist = -1, last_uhist = -1, last_umove = -1;
    int  last_rv_t = -1, last_c0 = 0, np = 0;

    // cyc mirrors the free-running fallback counter's time base (cleared by reset).
    always @(posedge clock) begin
        t   <= t + 1;
        cyc <= reset ? cyc + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("pred_req", 32'(pred_req), e_preq[t]);
            chk("result_valid", 32'(result_valid), e_rv[t]);
            chk("upd_valid", 32'(upd_valid), e_uv[t]);
            chk("busy", 32'(busy), e_busy[t]);
            chk("match_over", 32'(match_over), e_mo[t]);
            chk("ai_move", 32'(ai_move), e_ai[t]);
            chk("result", 32'(result), e_res[t]);
            chk("score_player", 32'(score_player), e_sp[t]);
            chk("score_ai", 32'(score_ai), e_sa[t]);
            if (e_preq[t] != 0) chk("pred_hist", 32'(pred_hist), e_phist[t]);
            if (e_uv[t] != 0) begin
                chk("upd_hist", 32'(upd_hist), e_uhist[t]);
                chk("upd_move", 32'(upd_move), e_umove[t]);
            end
            if (pred_req === 1'b1) begin n_preq++; last_phist = int'(pred_hist); end
            if (result_valid === 1'b1) last_rv_t = t;
            if (upd_valid === 1'b1) begin
                n_uv++; last_uhist = int'(upd_hist); last_umove = int'(upd_move);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_pred_req"}, 32'(pred_req), 0);
        chk({tag, "_pred_hist"}, 32'(pred_hist), 0);
        chk({tag, "_upd_valid"}, 32'(upd_valid), 0);
        chk({tag, "_upd_hist"}, 32'(upd_hist), 0);
        chk({tag, "_upd_move"}, 32'(upd_move), 0);
        chk({tag, "_result_valid"}, 32'(result_valid), 0);
        chk({tag, "_ai_move"}, 32'(ai_move), 0);
        chk({tag, "_result"}, 32'(result), 0);
        chk({tag, "_scores"}, 32'({score_player, score_ai}), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_match_over"}, 32'(match_over), 0);
    endtask

    // One round: play mv; predictor answers pm d cycles after the request (d<0: silent).
    // poke adds a legal play pulse while busy and a stray pred_valid in the result cycle.
    task automatic play(input logic [1:0] mv, input int d, input logic [1:0] pm, input bit poke);
        int c0, j, pr, ai, rs, last, m;
        bit acc;
        @(posedge clock); #1;
        c0 = t; last_c0 = t; m = int'(mv);
        acc = (mv != BAD) && !m_over;
        play_valid = 1'b1; play_move = mv;
        j = c0 + 2 + PT;
        if (acc) begin
            e_preq[c0+1] = 1; e_phist[c0+1] = m_hist;
            if (d < 0 || d > PT) pr = (cyc + 1 + PT) % 3;
            else begin
                j  = c0 + 2 + d;
                pr = (pm == BAD) ? (cyc + 1 + d) % 3 : int'(pm);
            end
            ai = (pr + 1) % 3;
            if (ai == m) rs = 1;
            else if (ai == (m + 1) % 3) rs = 3;
            else rs = 2;
            if (rs == 2 && m_sp < SMAX) m_sp++;
            if (rs == 3 && m_sa < SMAX) m_sa++;
            e_rv[j] = 1; e_uv[j+1] = 1; e_uhist[j+1] = m_hist; e_umove[j+1] = m;
            for (int c = c0 + 1; c <= j + 1; c++) e_busy[c] = 1;
            for (int c = j; c < N; c++) begin
                e_ai[c] = ai; e_res[c] = rs; e_sp[c] = m_sp; e_sa[c] = m_sa;
            end
            m_hist = m * 4 + ai;
`ifdef RPS_MATCH_LIMIT_EN
            if (m_sp == MW || m_sa == MW) begin
                m_over = 1'b1;
                for (int c = j + 2; c < N; c++) e_mo[c] = 1;
            end
`endif
        end
        last = acc ? j + 1 - c0 : 1;
        for (int k = 1; k <= last; k++) begin
            @(posedge clock); #1;
            play_valid = poke && k == 2;
            play_move  = (poke && k == 2) ? RK : mv;
            pred_valid = (acc && d >= 0 && k == 1 + d) || (poke && acc && k == j - c0);
            pred_move  = pm;
        end
        play_valid = 1'b0; pred_valid = 1'b0;
        @(negedge clock); #1;
    endtask

    // Call just after a posedge: reset is sampled at the next edge, outputs cleared after it.
    task automatic do_reset();
        int r;
        r = t;
        reset = 1'b0; play_valid = 1'b0; pred_valid = 1'b0;
        for (int c = r + 1; c < N; c++) begin
            e_preq[c] = 0; e_rv[c] = 0; e_uv[c] = 0; e_busy[c] = 0; e_mo[c] = 0;
            e_ai[c] = 0; e_res[c] = 0; e_sp[c] = 0; e_sa[c] = 0;
        end
        m_hist = 0; m_sp = 0; m_sa = 0; m_over = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic abort_round(input logic [1:0] mv, input int n);
        int c0, uv0;
        uv0 = n_uv;
        @(posedge clock); #1;
        c0 = t; play_valid = 1'b1; play_move = mv;
        e_preq[c0+1] = 1; e_phist[c0+1] = m_hist;
        for (int c = c0 + 1; c <= c0 + 1 + n; c++) e_busy[c] = 1;
        for (int k = 1; k <= n + 1; k++) begin
            @(posedge clock); #1;
            play_valid = 1'b0;
        end
        do_reset();
        @(negedge clock); #1;
        chk_zero("abort");
        repeat (12) @(posedge clock);
        #1;
        chk("abort_no_upd", n_uv, uv0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1; chk_en = 1'b1;
        @(negedge clock); #1;
        chk_zero("reset");
`ifndef RPS_MATCH_LIMIT_EN
        play(RK, 0, PA, 1'b0);
        chk("r1_latency", last_rv_t - last_c0, 2);
        chk("r1_ai_move", 32'(ai_move), 2);
        chk("r1_result", 32'(result), 2);
        chk("r1_score_player", 32'(score_player), 1);
        chk("r1_pred_hist", last_phist, 0);
        play(PA, -1, RK, 1'b0);
        chk("timeout_latency", last_rv_t - last_c0, 10);
        chk("r2_pred_hist", last_phist, 2);
        play(RK, 1, RK, 1'b0);
        chk("r3_result", 32'(result), 3);
        play(SC, 3, SC, 1'b0);
        chk("r4_pred_hist", last_phist, 1);
        chk("r4_upd_hist", last_uhist, 1);
        chk("r4_upd_move", last_umove, 2);
        chk("r4_ai_move", 32'(ai_move), 0);
        np = n_preq;
        play(BAD, 0, RK, 1'b0);
        chk("illegal_no_req", n_preq, np);
        play(PA, 2, BAD, 1'b1);
        chk("busy_poke_one_req", n_preq, np + 1);
        play(RK, PT, PA, 1'b0);
        chk("tie_latency", last_rv_t - last_c0, 10);
        chk("tie_ai_move", 32'(ai_move), 2);
        abort_round(SC, 3);
        for (int i = 0; i < 17; i++) play(RK, 0, RK, 1'b0);
        chk("sat_score_ai", 32'(score_ai), 15);
        chk("sat_score_player", 32'(score_player), 0);
`else
        play(RK, 0, RK, 1'b0);
        play(RK, 0, RK, 1'b0);
        chk("match_score_ai", 32'(score_ai), 2);
        np = n_preq;
        play(RK, 0, RK, 1'b0);
        chk("match_over_set", 32'(match_over), 1);
        chk("match_not_busy", 32'(busy), 0);
        chk("match_play_ignored", n_preq, np);
        chk("match_score_held", 32'(score_ai), 2);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
